// File: rtl/nco_tune_sched.sv
// nco_tune_sched: tuning scheduler for the shared 32-bit NCO.
// Arbitrates host base-increment retunes against tracking-loop frequency
// offsets, sequences the NCO reset/clock-enable around every retune and
// reports lock once the NCO output is valid again.
// Optional feature: define NCO_SCHED_TMO_EN to build the WAIT_VALID
// watchdog (timeout_err plus automatic retry); otherwise timeout_err is 0.
module nco_tune_sched #(
    parameter int unsigned        RST_CYC  = 7,
    parameter logic signed [31:0] FMOD_LIM = 32'sh1000_0000,
    parameter int unsigned        TMO_CYC  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_phi_inc,
    input  logic        trk_valid,
    output logic        trk_ready,
    input  logic [31:0] trk_fmod,
    output logic [31:0] nco_phi_inc,
    output logic [31:0] nco_freq_mod,
    output logic        nco_reset_n,
    output logic        nco_clken,
    input  logic        nco_out_valid,
    output logic        locked,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RESET,
        ST_WAIT_VALID,
        ST_RUN
    } state_t;

    localparam logic [7:0]         RST_LOAD = 8'(RST_CYC - 1);
    localparam logic signed [31:0] NEG_LIM  = -FMOD_LIM;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         rst_cnt;
    logic               rst_load;
    logic               cfg_acc;
    logic               trk_acc;
    logic signed [31:0] trk_s;
    logic [31:0]        fmod_sat;

`ifdef NCO_SCHED_TMO_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        tmo_err_q;
`endif

    // Tracking offset saturated to the symmetric limit (signed compare)
    always_comb begin
        trk_s    = trk_fmod;
        fmod_sat = trk_fmod;
        if (trk_s > FMOD_LIM) begin
            fmod_sat = FMOD_LIM;
        end else if (trk_s < NEG_LIM) begin
            fmod_sat = NEG_LIM;
        end
    end

    // Handshakes, next-state decode and state-derived NCO controls
    always_comb begin
        state_nxt = state;
        rst_load  = 1'b0;
`ifdef NCO_SCHED_TMO_EN
        tmo_hit   = 1'b0;
`endif
        cfg_ready = (state != ST_RESET);
        trk_ready = (state == ST_RUN) && !cfg_valid;
        cfg_acc   = cfg_valid && cfg_ready;
        trk_acc   = trk_valid && trk_ready;

        // enable low overrides everything; a host accept while parked
        // only updates the stored increment
        if (!enable) begin
            state_nxt = ST_OFF;
        end else if (cfg_acc) begin
            state_nxt = ST_RESET;
            rst_load  = 1'b1;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nxt = ST_RESET;
                    rst_load  = 1'b1;
                end
                ST_RESET: begin
                    if (rst_cnt == '0) begin
                        state_nxt = ST_WAIT_VALID;
                    end
                end
                ST_WAIT_VALID: begin
                    if (nco_out_valid) begin
                        state_nxt = ST_RUN;
                    end
`ifdef NCO_SCHED_TMO_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state_nxt = ST_RESET;
                        rst_load  = 1'b1;
                        tmo_hit   = 1'b1;
                    end
`endif
                end
                ST_RUN: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_OFF;
                end
            endcase
        end

        nco_reset_n = (state == ST_WAIT_VALID) || (state == ST_RUN);
        nco_clken   = (state != ST_OFF);
        locked      = (state == ST_RUN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // NCO settings and reset-length counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nco_phi_inc  <= '0;
            nco_freq_mod <= '0;
            rst_cnt      <= '0;
        end else begin
            if (cfg_acc) begin
                nco_phi_inc  <= cfg_phi_inc;
                nco_freq_mod <= '0;
            end else if (trk_acc) begin
                nco_freq_mod <= fmod_sat;
            end

            if (rst_load) begin
                rst_cnt <= RST_LOAD;
            end else if ((state == ST_RESET) && (rst_cnt != '0)) begin
                rst_cnt <= rst_cnt - 8'd1;
            end
        end
    end

`ifdef NCO_SCHED_TMO_EN
    // Watchdog: counts consecutive WAIT_VALID cycles, sticky error flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if ((state == ST_WAIT_VALID) && (state_nxt == ST_WAIT_VALID)) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_nco_tune_sched.sv
// Directed testbench for nco_tune_sched (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_nco_tune_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_phi_inc;
    logic        trk_valid;
    logic        trk_ready;
    logic [31:0] trk_fmod;
    logic [31:0] nco_phi_inc;
    logic [31:0] nco_freq_mod;
    logic        nco_reset_n;
    logic        nco_clken;
    logic        nco_out_valid;
    logic        locked;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    nco_tune_sched #(
        .RST_CYC  (7),
        .FMOD_LIM (32'sh1000_0000),
        .TMO_CYC  (64)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_phi_inc   (cfg_phi_inc),
        .trk_valid     (trk_valid),
        .trk_ready     (trk_ready),
        .trk_fmod      (trk_fmod),
        .nco_phi_inc   (nco_phi_inc),
        .nco_freq_mod  (nco_freq_mod),
        .nco_reset_n   (nco_reset_n),
        .nco_clken     (nco_clken),
        .nco_out_valid (nco_out_valid),
        .locked        (locked),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive samples with nco_reset_n low, starting with the
    // current one; returns with the first high sample showing (bounded).
    task automatic count_low(output int n);
        n = 0;
        while (nco_reset_n === 1'b0 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_phi_inc = '0;
        trk_valid = 1'b0; trk_fmod = '0; nco_out_valid = 1'b0;
        tick(); tick();
        n_vec++;
        if ({nco_phi_inc, nco_freq_mod} !== 64'h0) begin
            n_err++; $display("FAIL reset_regs got %h/%h exp 0/0", nco_phi_inc, nco_freq_mod);
        end
        n_vec++;
        if ({nco_reset_n, nco_clken, locked, timeout_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl got %b exp 0000", {nco_reset_n, nco_clken, locked, timeout_err});
        end
        n_vec++;
        if ({cfg_ready, trk_ready} !== 2'b10) begin
            n_err++; $display("FAIL reset_ready got %b exp 10", {cfg_ready, trk_ready});
        end
    endtask

    task automatic test_bringup();
        int n;
        bit early;
        reset_n = 1'b1; enable = 1'b1;
        cfg_valid = 1'b1; cfg_phi_inc = 32'h1000_0000;
        tick();
        cfg_valid = 1'b0;
        n_vec++;
        if (nco_phi_inc !== 32'h1000_0000) begin
            n_err++; $display("FAIL bringup_phi got %h exp 10000000", nco_phi_inc);
        end
        n_vec++;
        if ({nco_clken, cfg_ready} !== 2'b10) begin
            n_err++; $display("FAIL bringup_reset_ctl got %b exp 10", {nco_clken, cfg_ready});
        end
        count_low(n);
        n_vec++;
        if (n !== 7) begin
            n_err++; $display("FAIL bringup_low_len got %0d exp 7", n);
        end
        early = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (locked !== 1'b0 || nco_reset_n !== 1'b1) early = 1'b1;
            tick();
        end
        n_vec++;
        if (early !== 1'b0) begin
            n_err++; $display("FAIL bringup_wait got locked_early=1 exp 0");
        end
        nco_out_valid = 1'b1;
        tick();
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL bringup_lock got %b exp 1", locked);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vin [6];
        logic [31:0] vexp [6];
        vin[0] = 32'h7FFF_FFFF; vexp[0] = 32'h1000_0000;
        vin[1] = 32'h8000_0000; vexp[1] = 32'hF000_0000;
        vin[2] = 32'h0000_1234; vexp[2] = 32'h0000_1234;
        vin[3] = 32'h1000_0001; vexp[3] = 32'h1000_0000;
        vin[4] = 32'hF000_0000; vexp[4] = 32'hF000_0000;
        vin[5] = 32'hEFFF_FFFF; vexp[5] = 32'hF000_0000;
        trk_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            trk_fmod = vin[i];
            #1;
            n_vec++;
            if (trk_ready !== 1'b1) begin
                n_err++; $display("FAIL sat_ready[%0d] got %b exp 1", i, trk_ready);
            end
            tick();
            n_vec++;
            if (nco_freq_mod !== vexp[i] || locked !== 1'b1) begin
                n_err++; $display("FAIL sat[%0d] got %h lock %b exp %h lock 1", i, nco_freq_mod, locked, vexp[i]);
            end
        end
        trk_valid = 1'b0;
    endtask

    task automatic test_priority();
        int n;
        cfg_valid = 1'b1; cfg_phi_inc = 32'h2000_0000;
        trk_valid = 1'b1; trk_fmod = 32'h0000_0100;
        #1;
        n_vec++;
        if ({cfg_ready, trk_ready} !== 2'b10) begin
            n_err++; $display("FAIL prio_ready got %b exp 10", {cfg_ready, trk_ready});
        end
        tick();
        cfg_valid = 1'b0; trk_valid = 1'b0; nco_out_valid = 1'b0;
        n_vec++;
        if (nco_freq_mod !== 32'h0 || nco_phi_inc !== 32'h2000_0000) begin
            n_err++; $display("FAIL prio_regs got %h/%h exp 0/20000000", nco_freq_mod, nco_phi_inc);
        end
        n_vec++;
        if ({nco_reset_n, locked} !== 2'b00) begin
            n_err++; $display("FAIL prio_state got %b exp 00", {nco_reset_n, locked});
        end
        count_low(n);
        n_vec++;
        if (n !== 7) begin
            n_err++; $display("FAIL prio_low_len got %0d exp 7", n);
        end
    endtask

    task automatic test_retune_wait();
        int n;
        tick(); tick();
        cfg_valid = 1'b1; cfg_phi_inc = 32'h3000_0000;
        tick();
        cfg_valid = 1'b0;
        n_vec++;
        if (nco_phi_inc !== 32'h3000_0000) begin
            n_err++; $display("FAIL retune_phi got %h exp 30000000", nco_phi_inc);
        end
        count_low(n);
        n_vec++;
        if (n !== 7) begin
            n_err++; $display("FAIL retune_low_len got %0d exp 7", n);
        end
        nco_out_valid = 1'b1;
        tick();
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL retune_lock got %b exp 1", locked);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        cfg_valid = 1'b1; cfg_phi_inc = 32'h4000_0000;
        tick();
        cfg_valid = 1'b0; nco_out_valid = 1'b0;
        tick(); tick();
        enable = 1'b0;
        tick();
        n_vec++;
        if ({nco_clken, nco_reset_n, locked} !== 3'b000) begin
            n_err++; $display("FAIL endrop_ctl got %b exp 000", {nco_clken, nco_reset_n, locked});
        end
        n_vec++;
        if (nco_phi_inc !== 32'h4000_0000) begin
            n_err++; $display("FAIL endrop_phi got %h exp 40000000", nco_phi_inc);
        end
        cfg_valid = 1'b1; cfg_phi_inc = 32'h5000_0000;
        tick();
        cfg_valid = 1'b0;
        n_vec++;
        if (nco_phi_inc !== 32'h5000_0000 || nco_clken !== 1'b0) begin
            n_err++; $display("FAIL off_accept got %h clken %b exp 50000000 clken 0", nco_phi_inc, nco_clken);
        end
        enable = 1'b1;
        tick();
        n_vec++;
        if (nco_clken !== 1'b1) begin
            n_err++; $display("FAIL reenable_clken got %b exp 1", nco_clken);
        end
        count_low(n);
        n_vec++;
        if (n !== 7) begin
            n_err++; $display("FAIL reenable_low_len got %0d exp 7", n);
        end
    endtask

    task automatic test_watchdog();
        int hi;
        int n;
        hi = 0;
        while (nco_reset_n === 1'b1 && hi < 200) begin
            hi++;
            tick();
        end
`ifdef NCO_SCHED_TMO_EN
        n_vec++;
        if (hi !== 64) begin
            n_err++; $display("FAIL wdog_wait_len got %0d exp 64", hi);
        end
        n_vec++;
        if (timeout_err !== 1'b1) begin
            n_err++; $display("FAIL wdog_flag got %b exp 1", timeout_err);
        end
        count_low(n);
        n_vec++;
        if (n !== 7) begin
            n_err++; $display("FAIL wdog_retry_len got %0d exp 7", n);
        end
`else
        n = 0;
        n_vec++;
        if (hi !== 200 || nco_reset_n !== 1'b1) begin
            n_err++; $display("FAIL wdog_wait got high %0d exp 200", hi);
        end
        n_vec++;
        if (timeout_err !== 1'b0) begin
            n_err++; $display("FAIL wdog_flag got %b exp 0", timeout_err);
        end
`endif
        nco_out_valid = 1'b1;
        tick();
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL wdog_lock got %b exp 1", locked);
        end
    endtask

    task automatic test_mid_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; enable = 1'b0;
        n_vec++;
        if ({nco_phi_inc, nco_freq_mod} !== 64'h0) begin
            n_err++; $display("FAIL midrst_regs got %h/%h exp 0/0", nco_phi_inc, nco_freq_mod);
        end
        n_vec++;
        if ({nco_reset_n, nco_clken, locked, timeout_err} !== 4'b0000) begin
            n_err++; $display("FAIL midrst_ctl got %b exp 0000", {nco_reset_n, nco_clken, locked, timeout_err});
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_saturation();
        test_priority();
        test_retune_wait();
        test_enable_drop();
        test_watchdog();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nco_tune_sched.md
# nco_tune_sched

Tuning scheduler for the shared 32-bit NCO in the MSK demodulator. It arbitrates between two requesters: the host configuration port, which sets the base phase increment, and the carrier-tracking loop, which sets the signed frequency-modulation offset. It sequences the NCO's reset and clock enable around every base retune and reports when the NCO output is valid again. It sits between the control/tracking logic and the NCO's phi_inc_i, freq_mod_i, reset_n and clken inputs.

## Interface
- RST_CYC, 7: cycles nco_reset_n is held low per retune (range 1..255).
- FMOD_LIM, 32'h1000_0000: symmetric saturation limit applied to tracking offsets (positive, signed 32-bit).
- TMO_CYC, 64: maximum cycles to wait for nco_out_valid after reset release (used only with the watchdog).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low. Clock is clk.
- enable  in  1  run request; 0 parks the NCO.
- cfg_valid  in  1  host retune request.
- cfg_ready  out  1  host request accepted when cfg_valid & cfg_ready.
- cfg_phi_inc  in  32  new base phase increment (unsigned).
- trk_valid  in  1  tracking offset update.
- trk_ready  out  1  tracking handshake.
- trk_fmod  in  32  signed frequency offset.
- nco_phi_inc  out  32  drives NCO phi_inc_i.
- nco_freq_mod  out  32  drives NCO freq_mod_i.
- nco_reset_n  out  1  drives NCO reset_n.
- nco_clken  out  1  drives NCO clken.
- nco_out_valid  in  1  NCO out_valid.
- locked  out  1  NCO running with current settings and output valid.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: OFF, RESET, WAIT_VALID, RUN. reset_n low forces state OFF.
- Output reset values:
  - nco_phi_inc = 0, nco_freq_mod = 0.
  - nco_reset_n = 0, nco_clken = 0.
  - locked = 0, timeout_err = 0.
- Ready signals are combinational from state and inputs:
  - cfg_ready = 1 in every state except RESET.
  - trk_ready = 1 only in RUN and only while cfg_valid = 0. The host has priority on simultaneous requests, so trk_ready is 0 that cycle.
- Host accept (cfg_valid & cfg_ready):
  - nco_phi_inc <= cfg_phi_inc and nco_freq_mod <= 0.
  - If enable = 1, go to RESET with the RST_CYC counter loaded. If enable = 0, stay in OFF; the value is retained for later.
- OFF:
  - nco_reset_n = 0, nco_clken = 0, locked = 0.
  - When enable = 1, go to RESET.
- RESET:
  - nco_reset_n = 0, nco_clken = 1.
  - After exactly RST_CYC cycles, go to WAIT_VALID.
- WAIT_VALID:
  - nco_reset_n = 1, nco_clken = 1.
  - When nco_out_valid is sampled 1, go to RUN.
  - A host accept in this state restarts at RESET.
- RUN:
  - locked = 1 (registered, asserted on the cycle the state becomes RUN).
  - A host accept goes to RESET.
- Tracking accept: nco_freq_mod <= trk_fmod clamped to [-FMOD_LIM, +FMOD_LIM] using a signed compare. No reset is issued and locked stays 1.
- enable = 0 in any state forces OFF on the next cycle and drops locked. nco_phi_inc and nco_freq_mod are retained.
- A pending count in RESET is discarded if enable falls.

## Timing
- Host accept at cycle T:
  - nco_phi_inc valid at T+1.
  - nco_reset_n low at T+1 through T+RST_CYC, high from T+RST_CYC+1.
- nco_out_valid first seen high at cycle V: locked = 1 at V+1.
- Tracking accept at T: nco_freq_mod updated at T+1. One update per cycle is sustainable.
- enable falling at T: nco_clken = 0, nco_reset_n = 0 and locked = 0 at T+1.
- reset_n low mid-operation: all outputs take their reset values at the next edge, regardless of state.

## Configuration
- Macro NCO_SCHED_TMO_EN.
- Defined:
  - In WAIT_VALID a counter runs from 0.
  - If TMO_CYC cycles pass without nco_out_valid, set timeout_err (sticky until reset_n) and return to RESET for a fresh retry.
- Undefined:
  - WAIT_VALID waits indefinitely.
  - timeout_err is tied to 0 and no counter logic is built.

## Test plan
- Bring-up: reset, then cfg_phi_inc = 32'h1000_0000 with enable = 1, and the NCO model asserting out_valid 10 cycles after release -> nco_reset_n low for exactly 7 cycles, locked rises 1 cycle after out_valid.
- Saturation: in RUN, trk_fmod = 32'h7FFF_FFFF -> nco_freq_mod = 32'h1000_0000 next cycle; trk_fmod = 32'h8000_0000 -> 32'hF000_0000; trk_fmod = 32'h0000_1234 passes unchanged, and locked stays 1 throughout.
- Priority: cfg_valid and trk_valid both high in RUN -> trk_ready = 0, cfg accepted, nco_freq_mod = 0, state RESET.
- Retune during WAIT_VALID: second cfg accept -> RESET restarts with a full 7-cycle low pulse, and nco_phi_inc holds the new value.
- Enable drop mid-RESET at cycle 3 -> OFF next cycle with clken = 0; re-enable -> full 7-cycle reset sequence.
- Watchdog (NCO_SCHED_TMO_EN defined): out_valid held 0 -> timeout_err set after 64 cycles in WAIT_VALID, followed by a new RESET pulse. Without the macro, timeout_err stays 0 and the block waits indefinitely.
